// File: rtl/motion_arbiter.sv
// Motion request arbiter for the H-bridge driver: grants IR or autonomous moves
// and sequences each through soft-start, timed run, soft-stop and brake dead-time.
module motion_arbiter #(
    parameter int TICK_DIV     = 50000,
    parameter int RAMP_STEP    = 16,
    parameter int DUTY_MAX     = 240,
    parameter int IR_DUR_TICKS = 2000,
    parameter int DEAD_TICKS   = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        estop,
    input  logic        ir_valid,
    input  logic [2:0]  ir_cmd,
    output logic        ir_ready,
    input  logic        auto_valid,
    input  logic [2:0]  auto_cmd,
    input  logic [15:0] auto_dur,
    output logic        auto_ready,
    output logic [2:0]  drv_dir,
    output logic [7:0]  drv_duty,
    output logic        busy,
    output logic [1:0]  grant_src,
    output logic        cmd_err
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RAMP_UP, S_RUN, S_RAMP_DOWN, S_DEAD, S_ESTOP
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q;
    logic          tick;
    logic [15:0]   dur_q, dur_d, dead_q, dead_d;
    logic [7:0]    duty_q, duty_d;
    logic [2:0]    dir_q, dir_d;
    logic [1:0]    grant_q, grant_d;
    logic          ir_rdy_q, ir_rdy_d, au_rdy_q, au_rdy_d;
    logic          err_q, err_d, busy_q, busy_d;

    logic          acc, acc_move, preempt;
    logic [2:0]    acc_cmd;
    logic [15:0]   acc_dur;
    logic [1:0]    acc_src;
    logic [8:0]    up_sum;
    logic [7:0]    duty_up, duty_dn;

    assign tick = (presc_q == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) presc_q <= '0;
        else        presc_q <= tick ? '0 : presc_q + PW'(1);
    end

    // A ready pulse still high means the requester has not yet dropped valid,
    // so arbitration skips that cycle to avoid accepting the same request twice.
    always_comb begin
        acc     = 1'b0;
        acc_cmd = '0;
        acc_dur = '0;
        acc_src = '0;
        if (!ir_rdy_q && !au_rdy_q) begin
            if (ir_valid) begin
                acc     = 1'b1;
                acc_cmd = ir_cmd;
                acc_dur = 16'(IR_DUR_TICKS);
                acc_src = 2'd1;
            end else if (auto_valid) begin
                acc     = 1'b1;
                acc_cmd = auto_cmd;
                acc_dur = (auto_dur == 16'd0) ? 16'd1 : auto_dur;
                acc_src = 2'd2;
            end
        end
        acc_move = (acc_cmd != 3'd0) && (acc_cmd <= 3'd4);
        preempt  = (grant_q == 2'd2) && ir_valid && (ir_cmd != 3'd0) && (ir_cmd <= 3'd4);
        up_sum   = {1'b0, duty_q} + 9'(RAMP_STEP);
        duty_up  = (up_sum >= 9'(DUTY_MAX)) ? 8'(DUTY_MAX) : up_sum[7:0];
        duty_dn  = (duty_q > 8'(RAMP_STEP)) ? duty_q - 8'(RAMP_STEP) : '0;
    end

    always_comb begin
        state_d  = state_q;
        dur_d    = dur_q;
        dead_d   = dead_q;
        duty_d   = duty_q;
        dir_d    = dir_q;
        grant_d  = grant_q;
        ir_rdy_d = 1'b0;
        au_rdy_d = 1'b0;
        err_d    = 1'b0;
        if (estop) begin
            state_d = S_ESTOP;
            duty_d  = '0;
            dir_d   = '0;
            grant_d = 2'd3;
            dur_d   = '0;
            dead_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (acc) begin
                        ir_rdy_d = (acc_src == 2'd1);
                        au_rdy_d = (acc_src == 2'd2);
                        if (acc_move) begin
                            state_d = S_RAMP_UP;
                            dir_d   = acc_cmd;
                            grant_d = acc_src;
                            dur_d   = acc_dur;
                            duty_d  = '0;
                        end else if (acc_cmd != 3'd0) begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_RAMP_UP, S_RUN: begin
                    if (preempt) begin
                        state_d = S_RAMP_DOWN;
                    end else if (tick) begin
                        dur_d = (dur_q != 16'd0) ? dur_q - 16'd1 : '0;
                        if (state_q == S_RAMP_UP) duty_d = duty_up;
                        if (dur_q <= 16'd1)
                            state_d = S_RAMP_DOWN;
                        else if (state_q == S_RAMP_UP && duty_up == 8'(DUTY_MAX))
                            state_d = S_RUN;
                    end
                end
                S_RAMP_DOWN: begin
                    if (tick) begin
                        duty_d = duty_dn;
                        if (duty_dn == 8'd0) begin
                            dir_d   = '0;
                            dead_d  = 16'(DEAD_TICKS);
                            state_d = S_DEAD;
                        end
                    end
                end
                S_DEAD: begin
                    if (tick) begin
                        if (dead_q <= 16'd1) begin
                            dead_d  = '0;
                            grant_d = '0;
                            state_d = S_IDLE;
                        end else begin
                            dead_d = dead_q - 16'd1;
                        end
                    end
                end
                S_ESTOP: begin
                    dead_d  = 16'(DEAD_TICKS);
                    state_d = S_DEAD;
                end
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            dur_q    <= '0;
            dead_q   <= '0;
            duty_q   <= '0;
            dir_q    <= '0;
            grant_q  <= '0;
            ir_rdy_q <= 1'b0;
            au_rdy_q <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dur_q    <= dur_d;
            dead_q   <= dead_d;
            duty_q   <= duty_d;
            dir_q    <= dir_d;
            grant_q  <= grant_d;
            ir_rdy_q <= ir_rdy_d;
            au_rdy_q <= au_rdy_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign ir_ready   = ir_rdy_q;
    assign auto_ready = au_rdy_q;
    assign drv_dir    = dir_q;
    assign drv_duty   = duty_q;
    assign busy       = busy_q;
    assign grant_src  = grant_q;
    assign cmd_err    = err_q;
endmodule

// File: doc/motion_arbiter.md
Name: motion_arbiter

Overview:
Sequencing and arbitration controller placed in front of the H-bridge motor driver. Two requesters can ask for motion: the IR remote decoder and the autonomous navigation logic. The block grants one request at a time and drives a direction code and duty target to the driver. Each move soft-starts, holds for a timed duration, soft-stops, then passes through a brake dead-time before the next move. An emergency-stop input overrides everything.

Parameters:
TICK_DIV, 50000, clocks per timebase tick (1 ms at 50 MHz)
RAMP_STEP, 16, duty change applied per tick while ramping
DUTY_MAX, 240, run duty (8-bit)
IR_DUR_TICKS, 2000, hold duration in ticks for IR commands
DEAD_TICKS, 20, brake dead-time in ticks between moves

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
estop  in  1  emergency stop, level, synchronous sample
ir_valid  in  1  IR request valid, held until ir_ready
ir_cmd  in  3  0 stop, 1 fwd, 2 back, 3 left, 4 right, 5-7 invalid
ir_ready  out  1  one-cycle accept pulse to IR requester
auto_valid  in  1  autonomous request valid, held until auto_ready
auto_cmd  in  3  same encoding as ir_cmd
auto_dur  in  16  hold duration in ticks for auto commands
auto_ready  out  1  one-cycle accept pulse to auto requester
drv_dir  out  3  direction to driver, same encoding; 0 means brake
drv_duty  out  8  duty target to driver PWM
busy  out  1  high in every state except IDLE
grant_src  out  2  0 none, 1 IR, 2 auto, 3 estop
cmd_err  out  1  one-cycle pulse when an invalid cmd (5-7) is accepted

Behaviour:
- Reset (async, rst_n low): state IDLE; drv_dir=0, drv_duty=0, ir_ready=0, auto_ready=0, busy=0, grant_src=0, cmd_err=0; prescaler, duration and dead counters all 0.
- Prescaler: free-running 0..TICK_DIV-1. tick is high for one clk when the count wraps. Not reset by state changes.
- States: IDLE, RAMP_UP, RUN, RAMP_DOWN, DEAD, ESTOP. All outputs are registered.
- IDLE arbitration uses fixed priority: estop, then IR, then auto. A request sampled in cycle N produces its ready pulse in cycle N+1. In that same cycle N+1, drv_dir=cmd, grant_src is set, the duration counter is loaded, and the state moves to RAMP_UP with drv_duty=0. Valid is not sampled again until the next IDLE.
- Duration load: IR_DUR_TICKS for IR, auto_dur for auto. auto_dur=0 is treated as 1.
- cmd 0 is accepted with a ready pulse and no motion; the state stays IDLE. cmd 5-7 is accepted with a ready pulse plus cmd_err; the state stays IDLE.
- RAMP_UP: on each tick, drv_duty = min(drv_duty+RAMP_STEP, DUTY_MAX). When drv_duty equals DUTY_MAX, go to RUN.
- RAMP_UP and RUN: the duration counter decrements on each tick. At 0, go to RAMP_DOWN. This is allowed directly from RAMP_UP if the duration expires early.
- RAMP_DOWN: on each tick, drv_duty = max(drv_duty-RAMP_STEP, 0), saturating with no underflow. At 0, drv_dir=0, the dead counter loads DEAD_TICKS, and the state goes to DEAD.
- DEAD: the dead counter decrements on each tick. At 0: IDLE, grant_src=0.
- Preemption: while grant_src=2 in RAMP_UP or RUN, ir_valid with a cmd in 1-4 forces RAMP_DOWN on the next cycle. The IR request is not acknowledged until IDLE. IR moves are never preempted by auto.
- estop high in any state: next cycle drv_duty=0, drv_dir=0, grant_src=3, state ESTOP. No ready pulses while estop is high, including when it coincides with valid.
- estop release: leaving ESTOP loads DEAD_TICKS, goes to DEAD, then IDLE. The interrupted move is discarded with no resume.
- Reset asserted mid-move returns all outputs to reset values immediately.

Test Plan:
All scenarios use bench parameters TICK_DIV=4, RAMP_STEP=64, DUTY_MAX=192, IR_DUR_TICKS=8, DEAD_TICKS=2.
1. ir_valid with ir_cmd=1 from IDLE -> ir_ready one cycle later; drv_dir=1; drv_duty steps 0,64,128,192 on successive ticks; RAMP_DOWN after 8 ticks from accept; duty 128,64,0; drv_dir=0; IDLE 2 ticks later with busy=0.
2. ir_valid and auto_valid in the same cycle -> only ir_ready pulses and grant_src=1. auto_ready pulses exactly once, in the cycle after the next IDLE.
3. auto move with auto_cmd=3, auto_dur=20; ir_valid with ir_cmd=4 raised while in RUN -> RAMP_DOWN next cycle, then DEAD. ir_ready, drv_dir=4 and grant_src=1 follow after IDLE.
4. estop pulsed during RUN -> next cycle drv_duty=0, drv_dir=0, grant_src=3. After release, DEAD lasts 2 ticks, then IDLE. The pending ir_valid is not acknowledged while estop is high.
5. auto_cmd=6 -> auto_ready and cmd_err pulse together, state stays IDLE, drv_dir=0. auto_cmd=2 with auto_dur=0 -> runs 1 tick, reaching drv_duty=64 only, then ramps down.
6. rst_n asserted during RAMP_UP -> all outputs 0 asynchronously. After release, the first tick occurs 4 clocks later.
